bin_to_bcd_scan: RTL and testbench
==================================

Name: bin_to_bcd_scan

Overview:
Upstream feeder for the BCD-to-seven-segment decoder. It accepts a binary value over a valid/ready handshake and converts it to packed BCD using the sequential double-dabble method, one bit per cycle. It then time-multiplexes the held digits onto a single 4-bit BCD bus with a one-hot digit select. The decoder consumes `bcd` and turns it into segment drives. The CPU result/debug path sits upstream.

Parameters:
- WIDTH, 16: binary input width.
- DIGITS, 5: BCD digits held and scanned. Must satisfy 10^DIGITS > 2^WIDTH.
- SCAN_DIV, 50000: clock cycles each digit stays selected. Must be >= 1.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_value is valid.
- in_ready  out  1  block can accept a value. High only in IDLE.
- in_value  in  WIDTH  unsigned binary to display.
- blank_lz  in  1  1 = blank leading zeros.
- conv_done  out  1  one-cycle pulse when a new value reaches the display register.
- bcd  out  4  BCD digit for the decoder. 4'hF = blank (decoder drives all segments off).
- digit_sel  out  DIGITS  one-hot active-high digit enable. Bit 0 = least-significant digit.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, so in_ready = 1.
  - conv_done = 0.
  - Display register = all digits 0.
  - Scan index = 0, prescaler = 0.
  - Therefore digit_sel = 1 and bcd = 0.
- Handshake:
  - A transfer occurs on an edge where in_valid && in_ready.
  - in_value is captured into the low WIDTH bits of the scratch register. The BCD field (4*DIGITS bits) is cleared and the bit counter is cleared.
  - in_valid while in_ready = 0 is ignored. The source must hold the value until accepted.
- FSM:
  - IDLE -> SHIFT on transfer.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift the whole scratch register left by 1. Both happen in the same cycle.
  - SHIFT -> DONE after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1).
  - DONE: copy the BCD field into the display register, assert conv_done, go to IDLE.
- Latency:
  - Transfer on edge 0 gives SHIFT on edges 1..WIDTH and the display/conv_done update on edge WIDTH+1.
  - conv_done is registered, high for exactly one cycle.
  - Next transfer is possible at edge WIDTH+2 at the earliest.
- Display stability:
  - The display register holds the previous value throughout a conversion, so there is no flicker.
  - No intermediate value is ever visible.
- Scanner (runs independently of the FSM, including during conversion):
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the terminal count, scan index increments, wrapping DIGITS-1 -> 0.
  - SCAN_DIV = 1 advances every cycle.
- Outputs:
  - digit_sel = one-hot(index).
  - bcd = display[index], or 4'hF if blanked.
  - Both are decoded from registers only.
- Blanking:
  - With blank_lz = 1, digit i (i >= 1) is blanked when digits i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so the value 0 shows "0".
  - blank_lz takes effect combinationally.
- Reset mid-conversion:
  - The conversion is abandoned and the display register clears to 0.
  - No conv_done pulse is produced.
  - in_ready = 1 the cycle after.
- Widths:
  - Scratch register is WIDTH + 4*DIGITS bits.
  - Bit counter is $clog2(WIDTH) bits.
  - Index is $clog2(DIGITS) bits, with minimum 1.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, SHIFT, DONE}.
  - BCD_BLANK = 4'hF.
  - Helper function for the required DIGITS given WIDTH, used in an elaboration-time check.
- One sub-module: bcd_dabble_adjust. This is combinational: it takes 4*DIGITS bits in, applies add-3 per nibble >= 5, and outputs the result. The parent instantiates it in the SHIFT datapath.

Test Plan:
1. Reset, no input -> in_ready = 1, conv_done = 0, digit_sel = 5'b00001, bcd = 0. After SCAN_DIV = 2: digit_sel = 5'b00010, bcd = 0.
2. in_value = 12345, blank_lz = 0, SCAN_DIV = 2:
   - conv_done high exactly 17 cycles after the transfer edge.
   - in_ready low for 17 cycles.
   - Scan shows bcd 5, 4, 3, 2, 1 for digit_sel bits 0..4, 2 cycles each, then wraps.
3. in_value = 65535 -> digits 5, 3, 5, 5, 6 (LSD first). in_value = 0 -> all digits 0.
4. blank_lz = 1:
   - Value 42 -> bcd 2, 4, F, F, F.
   - Value 0 -> 0, F, F, F, F.
   - Value 10005 -> 5, 0, 0, 0, 1 (inner zeros are not blanked).
5. Load 12345, then hold in_valid with 7 from 3 cycles after the transfer -> 7 is not accepted until in_ready returns. The display shows 12345 until the second conv_done, then 7.
6. Load 999 and complete, then load 65535 and assert rst on SHIFT cycle 8 -> no conv_done, display digits all 0, state IDLE, in_ready = 1 one cycle after rst is released.

Source files
------------

// File: rtl/bin_to_bcd_scan_pkg.sv
// Shared types and constants for the binary-to-BCD converter and digit scanner.
// Also provides the digit-count helper used to validate WIDTH/DIGITS pairings.
package bin_to_bcd_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Smallest digit count d with 10^d > 2^width (valid for width < 64).
   function automatic int req_digits(input int width);
      longint unsigned p2;
      longint unsigned p10;
      int d;
      p2  = 64'd1 << width;
      p10 = 64'd10;
      d   = 1;
      while (p10 <= p2) begin
         p10 = p10 * 64'd10;
         d   = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_dabble_adjust.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_dabble_adjust
   import bin_to_bcd_scan_pkg::*;
#(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [4*DIGITS-1:0] bcd_out
);

   for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      assign bcd_out[4*i +: 4] = (bcd_in[4*i +: 4] >= 4'd5) ? (bcd_in[4*i +: 4] + 4'd3)
                                                           : bcd_in[4*i +: 4];
   end

endmodule

// File: rtl/bin_to_bcd_scan.sv
// Sequential binary-to-BCD converter feeding a multiplexed 7-segment decoder:
// one bit per cycle double-dabble, held display register, free-running digit scan.
module bin_to_bcd_scan
   import bin_to_bcd_scan_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_value,
   input  logic              blank_lz,
   output logic              conv_done,
   output logic [3:0]        bcd,
   output logic [DIGITS-1:0] digit_sel
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = WIDTH + BW;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   if (DIGITS < req_digits(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_scan: DIGITS too small for WIDTH");
   end
   if (SCAN_DIV < 1) begin : g_bad_div
      $error("bin_to_bcd_scan: SCAN_DIV must be >= 1");
   end

   state_t          state;
   state_t          state_n;
   logic [SW-1:0]   scratch;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   display;
   logic [BW-1:0]   adjusted;
   logic [IW-1:0]   idx;
   logic [PW-1:0]   pre;
   logic            xfer;
   logic [3:0]      digits [DIGITS];
   logic [DIGITS-1:0] blank;
   logic            zero_above;

   assign xfer = in_valid && in_ready;

   bcd_dabble_adjust #(
      .DIGITS (DIGITS)
   ) u_adjust (
      .bcd_in  (scratch[SW-1:WIDTH]),
      .bcd_out (adjusted)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = SHIFT;
         end
         SHIFT: begin
            if (cnt == CW'(WIDTH - 1)) state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Conversion datapath: capture, adjust-and-shift, publish to display.
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_done <= 1'b0;
         display   <= '0;
      end else begin
         conv_done <= (state == DONE);
         if (state == DONE) display <= scratch[SW-1:WIDTH];
      end
      if (xfer) begin
         scratch <= {{BW{1'b0}}, in_value};
         cnt     <= '0;
      end else if (state == SHIFT) begin
         scratch <= {adjusted, scratch[WIDTH-1:0]} << 1;
         cnt     <= cnt + CW'(1);
      end
   end

   // Scanner: independent of the FSM so the display keeps refreshing mid-conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PW'(SCAN_DIV - 1)) begin
         pre <= '0;
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = 0; i < DIGITS; i++) digits[i] = display[4*i +: 4];
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (digits[i] == 4'd0);
         blank[i]   = blank_lz && zero_above;
      end
   end

   assign digit_sel = DIGITS'(1) << idx;
   assign bcd       = blank[idx] ? BCD_BLANK : digits[idx];

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed bench for bin_to_bcd_scan: scoreboard of accepted values, a
// free-running scan model, and per-cycle checks of the multiplexed outputs.
module tb_bin_to_bcd_scan;

   localparam int WIDTH    = 16;
   localparam int DIGITS   = 5;
   localparam int SCAN_DIV = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_value;
   logic              blank_lz;
   logic              conv_done;
   logic [3:0]        bcd;
   logic [DIGITS-1:0] digit_sel;

   int checks = 0;
   int errors = 0;
   int q[$];
   int disp_m;
   int pre_m;
   int idx_m;

   bin_to_bcd_scan #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .blank_lz  (blank_lz),
      .conv_done (conv_done),
      .bcd       (bcd),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   // Scan position model.
   always @(posedge clk) begin
      if (rst) begin
         pre_m <= 0;
         idx_m <= 0;
      end else if (pre_m == SCAN_DIV - 1) begin
         pre_m <= 0;
         idx_m <= (idx_m == DIGITS - 1) ? 0 : idx_m + 1;
      end else begin
         pre_m <= pre_m + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] exp_digit(input int v, input logic bl, input int i);
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (bl && i >= 1 && v < p) return 4'hF;
      return 4'((v / p) % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update scoreboard/display model, then check the scanned outputs.
   task automatic step();
      logic r;
      r = rst;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         disp_m = 0;
      end else if (conv_done) begin
         chk("done_expected", (q.size() != 0), 1);
         if (q.size() != 0) disp_m = q.pop_front();
      end
      chk("digit_sel", digit_sel, 32'(1) << idx_m);
      chk("bcd", bcd, exp_digit(disp_m, blank_lz, idx_m));
   endtask

   task automatic load(input int v);
      int n;
      in_valid = 1'b1;
      in_value = WIDTH'(v);
      n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      chk("ready_wait", in_ready, 1);
      q.push_back(v);
      step();
      in_valid = 1'b0;
      chk("ready_low_after_xfer", in_ready, 0);
   endtask

   // Returns cycles from the transfer edge to conv_done and cycles with in_ready low.
   task automatic wait_done(output int lat, output int lows);
      lat  = -1;
      lows = 1;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (conv_done) begin
            lat = k;
            break;
         end
         if (!in_ready) lows++;
      end
      chk("done_timeout", (lat > 0), 1);
   endtask

   task automatic scan(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int lat;
      int lows;
      int dones;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      blank_lz = 1'b0;
      disp_m   = 0;

      // 1: reset state and first scan advance
      step();
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_conv_done", conv_done, 0);
      chk("rst_digit_sel", digit_sel, 5'b00001);
      chk("rst_bcd", bcd, 0);
      rst = 1'b0;
      step();
      step();
      chk("scan_adv_sel", digit_sel, 5'b00010);
      chk("scan_adv_bcd", bcd, 0);

      // 2: 12345, latency and ready window
      load(12345);
      wait_done(lat, lows);
      chk("lat_12345", lat, 17);
      chk("ready_low_12345", lows, 17);
      chk("done_ready", in_ready, 1);
      step();
      chk("done_one_cycle", conv_done, 0);
      scan(2 * DIGITS * SCAN_DIV);

      // 3: full-scale and zero
      load(65535);
      wait_done(lat, lows);
      chk("lat_65535", lat, 17);
      scan(2 * DIGITS * SCAN_DIV);
      load(0);
      wait_done(lat, lows);
      scan(2 * DIGITS * SCAN_DIV);

      // 4: leading-zero blanking
      blank_lz = 1'b1;
      scan(DIGITS * SCAN_DIV);
      load(42);
      wait_done(lat, lows);
      scan(2 * DIGITS * SCAN_DIV);
      load(10005);
      wait_done(lat, lows);
      scan(2 * DIGITS * SCAN_DIV);
      blank_lz = 1'b0;
      scan(DIGITS * SCAN_DIV);

      // 5: back-pressured second value
      load(12345);
      step();
      step();
      step();
      in_valid = 1'b1;
      in_value = WIDTH'(7);
      lat = -1;
      for (int k = 4; k <= 100; k++) begin
         step();
         if (conv_done) begin
            lat = k;
            break;
         end
         chk("held_ready_low", in_ready, 0);
      end
      chk("lat_first", lat, 17);
      q.push_back(7);
      step();
      in_valid = 1'b0;
      chk("second_xfer_ready", in_ready, 0);
      wait_done(lat, lows);
      chk("lat_second", lat, 17);
      scan(2 * DIGITS * SCAN_DIV);

      // 6: reset in the middle of a conversion
      load(999);
      wait_done(lat, lows);
      scan(DIGITS * SCAN_DIV);
      load(65535);
      for (int k = 1; k < 8; k++) step();
      rst = 1'b1;
      step();
      chk("midrst_done", conv_done, 0);
      chk("midrst_ready", in_ready, 1);
      rst = 1'b0;
      step();
      chk("post_rst_ready", in_ready, 1);
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (conv_done) dones++;
      end
      chk("no_done_after_rst", dones, 0);
      chk("idle_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
